// File: rtl/shock_pulse_emu_if.sv
// ADC stream bundle: three twin-sample channel words plus a common valid flag.
interface shock_pulse_emu_if #(
    parameter int ADC_TWIN_DATA_WIDTH = 32
);
    logic [ADC_TWIN_DATA_WIDTH-1:0] adc_data_a;
    logic [ADC_TWIN_DATA_WIDTH-1:0] adc_data_b;
    logic [ADC_TWIN_DATA_WIDTH-1:0] adc_data_c;
    logic                           adc_valid;

    modport master (
        output adc_data_a,
        output adc_data_b,
        output adc_data_c,
        output adc_valid
    );

    modport slave (
        input adc_data_a,
        input adc_data_b,
        input adc_data_c,
        input adc_valid
    );
endinterface

// File: rtl/shock_pulse_emu.sv
// Synthetic shock-tube pulse source: baseline plus rectangular pulses on
// channels A, B, C at programmable delays, optional LFSR dither, saturated.
module shock_pulse_emu #(
    parameter int          C_S_AXI_DATA_WIDTH  = 32,
    parameter int          ADC_DATA_WIDTH      = 16,
    parameter int          ADC_TWIN_DATA_WIDTH = 32,
    parameter logic [15:0] LFSR_SEED           = 16'hACE1
) (
    input  logic                               rxclk,
    input  logic                               resetn,
    input  logic                               emu_enable,
    input  logic                               emu_start,
    input  logic signed [ADC_DATA_WIDTH-1:0]   baseline,
    input  logic signed [ADC_DATA_WIDTH-1:0]   amp_a,
    input  logic signed [ADC_DATA_WIDTH-1:0]   amp_b,
    input  logic signed [ADC_DATA_WIDTH-1:0]   amp_c,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]      delay_ab,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]      delay_bc,
    input  logic [15:0]                        pulse_len,
    input  logic                               noise_en,
    shock_pulse_emu_if.master                  adc,
    output logic                               emu_busy,
    output logic                               emu_done,
    output logic [15:0]                        run_count
);
    localparam int W  = ADC_DATA_WIDTH;
    localparam int SW = ADC_DATA_WIDTH + 2;      // headroom for base+amp+dither
    localparam int TW = C_S_AXI_DATA_WIDTH + 2;  // delay_ab+delay_bc+len never overflows

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_nxt;
    logic                 load, finish;
    logic [TW-1:0]        t, t_end, b_start, b_end, c_start, len_l;
    logic signed [W-1:0]  base_l, amp_a_l, amp_b_l, amp_c_l;
    logic                 noise_l;
    logic [15:0]          lfsr;

    // Clip an extended sum back to W bits; in range iff the top three bits agree.
    function automatic logic signed [W-1:0] sat(input logic signed [SW-1:0] v);
        logic signed [W-1:0] r;
        if ((v[SW-1:W-1] == 3'b000) || (v[SW-1:W-1] == 3'b111))
            r = v[W-1:0];
        else if (v[SW-1])
            r = {1'b1, {(W-1){1'b0}}};
        else
            r = {1'b0, {(W-1){1'b1}}};
        return r;
    endfunction

    // One sample: baseline + optional pulse amplitude + optional 3-bit dither.
    function automatic logic signed [W-1:0] sample(
        input logic signed [W-1:0] base,
        input logic signed [W-1:0] amp,
        input logic                act,
        input logic [2:0]          dith,
        input logic                nz
    );
        logic signed [SW-1:0] sum;
        sum = {{2{base[W-1]}}, base};
        if (act) sum = sum + {{2{amp[W-1]}}, amp};
        if (nz)  sum = sum + {{(SW-3){dith[2]}}, dith};
        return sat(sum);
    endfunction

    // Next state; a dropped enable overrides every other transition.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: if (emu_start) begin state_nxt = RUN; load = 1'b1; end
            RUN:  if (t == t_end) begin state_nxt = DONE; finish = 1'b1; end
            DONE: if (emu_start) begin state_nxt = RUN; load = 1'b1; end
            default: state_nxt = IDLE;
        endcase
        if (!emu_enable) begin
            state_nxt = IDLE;
            load      = 1'b0;
            finish    = 1'b0;
        end
    end

    // State register, completion strobe and run counter.
    always_ff @(posedge rxclk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            emu_done  <= 1'b0;
            run_count <= '0;
        end else begin
            state    <= state_nxt;
            emu_done <= finish;
            if (finish) run_count <= run_count + 16'd1;
        end
    end

    // Latch the run configuration on start and advance the run timer.
    always_ff @(posedge rxclk or negedge resetn) begin
        if (!resetn) begin
            t       <= '0;
            t_end   <= '0;
            b_start <= '0;
            b_end   <= '0;
            c_start <= '0;
            len_l   <= '0;
            base_l  <= '0;
            amp_a_l <= '0;
            amp_b_l <= '0;
            amp_c_l <= '0;
            noise_l <= 1'b0;
        end else if (load) begin
            t       <= '0;
            len_l   <= TW'(pulse_len);
            b_start <= TW'(delay_ab);
            b_end   <= TW'(delay_ab) + TW'(pulse_len);
            c_start <= TW'(delay_ab) + TW'(delay_bc);
            t_end   <= TW'(delay_ab) + TW'(delay_bc) + TW'(pulse_len);
            base_l  <= baseline;
            amp_a_l <= amp_a;
            amp_b_l <= amp_b;
            amp_c_l <= amp_c;
            noise_l <= noise_en;
        end else if (state == RUN) begin
            t <= t + TW'(1);
        end
    end

    logic                in_run, act_a, act_b, act_c, nz;
    logic signed [W-1:0] base_e;

    assign in_run   = (state == RUN);
    assign emu_busy = in_run;
    assign act_a    = in_run && (t < len_l);
    assign act_b    = in_run && (t >= b_start) && (t < b_end);
    assign act_c    = in_run && (t >= c_start) && (t < t_end);
    assign base_e   = in_run ? base_l : baseline;
    assign nz       = in_run ? noise_l : noise_en;

    // Registered output words, valid flag and free-running dither LFSR.
    always_ff @(posedge rxclk or negedge resetn) begin
        if (!resetn) begin
            adc.adc_data_a <= '0;
            adc.adc_data_b <= '0;
            adc.adc_data_c <= '0;
            adc.adc_valid  <= 1'b0;
            lfsr           <= LFSR_SEED;
        end else begin
            adc.adc_data_a <= {sample(base_e, amp_a_l, act_a, lfsr[5:3], nz),
                               sample(base_e, amp_a_l, act_a, lfsr[2:0], nz)};
            adc.adc_data_b <= {sample(base_e, amp_b_l, act_b, lfsr[5:3], nz),
                               sample(base_e, amp_b_l, act_b, lfsr[2:0], nz)};
            adc.adc_data_c <= {sample(base_e, amp_c_l, act_c, lfsr[5:3], nz),
                               sample(base_e, amp_c_l, act_c, lfsr[2:0], nz)};
            adc.adc_valid  <= emu_enable;
            lfsr           <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end
endmodule
